// File: rtl/conv_inst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_inst_sequencer: kij-wise core instruction and array-reset sequencer |
// | with computed-address psum accumulation.                    Rev 1.0      |
// +--------------------------------------------------------------------------+
module conv_inst_sequencer #(
  parameter int          COL     = 8,
  parameter int          IN_W    = 4,
  parameter int          K_W     = 3,
  parameter int          RST_CYC = 2,
  parameter int          GAP     = 10,
  parameter logic [10:0] WBASE   = 11'h400,
  parameter logic [10:0] ABASE   = 11'h000,
  parameter logic [10:0] PBASE   = 11'h000,
  localparam int         OUT_W    = IN_W - K_W + 1,
  localparam int         LEN_ONIJ = OUT_W * OUT_W,
  localparam int         OIDX_W   = (LEN_ONIJ > 1) ? $clog2(LEN_ONIJ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [OIDX_W-1:0] out_idx,
  output logic              core_rst,
  output logic [33:0]       inst
);

  localparam int          LEN_NIJ   = IN_W * IN_W;
  localparam int          LEN_KIJ   = K_W * K_W;
  localparam int          CW        = 16;
  localparam int          KW        = (LEN_KIJ > 1) ? $clog2(LEN_KIJ) : 1;
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  if (LEN_KIJ * LEN_NIJ + int'(PBASE) > 2048) begin : g_addr_range_check
    $error("conv_inst_sequencer: psum region does not fit in PMEM");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_K_RST, S_W_L0, S_W_LD, S_GAPS, S_A_L0,
    S_EXEC, S_P_WR, S_O_RST, S_ACC, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       t_q, t_d, lim;
  logic [KW-1:0]       kij_q, kij_d;
  logic [OIDX_W-1:0]   o_q, o_d, out_idx_q, out_idx_d;
  logic [CW-1:0]       orow_q, orow_d, ocol_q, ocol_d, ki_q, ki_d, kj_q, kj_d;
  logic [10:0]         wptr_q, wptr_d;
  logic [33:0]         inst_q, inst_d;
  logic                busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
  logic                core_rst_q, core_rst_d, wr_fire, t_last;

  always_comb begin
    lim = CW'(1);
    case (state_q)
      S_K_RST, S_O_RST: lim = CW'(RST_CYC);
      S_W_L0, S_W_LD:   lim = CW'(COL);
      S_GAPS:           lim = CW'(GAP);
      S_A_L0, S_EXEC:   lim = CW'(LEN_NIJ);
      default:          lim = CW'(1);
    endcase
    t_last = (t_q == lim - CW'(1));
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q + CW'(1);
    kij_d       = kij_q;
    o_d         = o_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    ki_d        = ki_q;
    kj_d        = kj_q;
    wptr_d      = wptr_q;
    wr_fire     = 1'b0;
    out_valid_d = 1'b0;
    out_idx_d   = out_idx_q;
    case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start) begin
          state_d = S_K_RST;
          kij_d   = '0;
          wptr_d  = PBASE;
        end
      end
      S_K_RST: if (t_last) begin state_d = S_W_L0; t_d = '0; end
      S_W_L0:  if (t_last) begin state_d = S_W_LD; t_d = '0; end
      S_W_LD:  if (t_last) begin state_d = S_GAPS; t_d = '0; end
      S_GAPS:  if (t_last) begin state_d = S_A_L0; t_d = '0; end
      S_A_L0:  if (t_last) begin state_d = S_EXEC; t_d = '0; end
      S_EXEC:  if (t_last) begin state_d = S_P_WR; t_d = '0; end
      S_P_WR: begin
        // t counts completed writes; the cycle after the last write moves on
        t_d = t_q;
        if (t_q == CW'(LEN_NIJ)) begin
          t_d = '0;
          if (kij_q == KW'(LEN_KIJ - 1)) begin
            state_d = S_O_RST;
            o_d     = '0;
            orow_d  = '0;
            ocol_d  = '0;
          end else begin
            state_d = S_K_RST;
            kij_d   = kij_q + KW'(1);
          end
        end else if (ofifo_valid) begin
          wr_fire = 1'b1;
          t_d     = t_q + CW'(1);
          wptr_d  = wptr_q + 11'd1;
        end
      end
      S_O_RST: if (t_last) begin state_d = S_ACC; t_d = '0; ki_d = '0; kj_d = '0; end
      S_ACC: begin
        if (t_q == CW'(LEN_KIJ + 1)) begin
          out_valid_d = 1'b1;
          out_idx_d   = o_q;
          t_d         = '0;
          if (o_q == OIDX_W'(LEN_ONIJ - 1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_O_RST;
            o_d     = o_q + OIDX_W'(1);
            if (ocol_q == CW'(OUT_W - 1)) begin
              ocol_d = '0;
              orow_d = orow_q + CW'(1);
            end else begin
              ocol_d = ocol_q + CW'(1);
            end
          end
        end else if (kj_q == CW'(K_W - 1)) begin
          kj_d = '0;
          ki_d = ki_q + CW'(1);
        end else begin
          kj_d = kj_q + CW'(1);
        end
      end
      S_DONE:  begin state_d = S_IDLE; t_d = '0; end
      default: begin state_d = S_IDLE; t_d = '0; end
    endcase

    // Outputs are decoded from the upcoming state so the registered bus lines up with it
    inst_d     = INST_IDLE;
    core_rst_d = 1'b0;
    case (state_d)
      S_K_RST, S_O_RST: core_rst_d = 1'b1;
      S_W_L0: begin
        inst_d[19]   = 1'b0;
        inst_d[2]    = 1'b1;
        inst_d[17:7] = WBASE + 11'(kij_d) * 11'(COL) + 11'(t_d);
      end
      S_W_LD: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
      end
      S_A_L0: begin
        inst_d[19]   = 1'b0;
        inst_d[2]    = 1'b1;
        inst_d[17:7] = ABASE + 11'(t_d);
      end
      S_EXEC: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
      end
      S_ACC: begin
        if (t_d < CW'(LEN_KIJ)) begin
          inst_d[32]    = 1'b0;
          inst_d[30:20] = PBASE + 11'(t_d) * 11'(LEN_NIJ)
                        + 11'(orow_d + ki_d) * 11'(IN_W) + 11'(ocol_d + kj_d);
        end
        if ((t_d != '0) && (t_d <= CW'(LEN_KIJ))) inst_d[33] = 1'b1;
      end
      default: ;
    endcase
    if (wr_fire) begin
      inst_d[6]     = 1'b1;
      inst_d[32]    = 1'b0;
      inst_d[31]    = 1'b0;
      inst_d[30:20] = wptr_q;
    end
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      t_q         <= '0;
      kij_q       <= '0;
      o_q         <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      ki_q        <= '0;
      kj_q        <= '0;
      wptr_q      <= PBASE;
      inst_q      <= INST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      core_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      kij_q       <= kij_d;
      o_q         <= o_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      ki_q        <= ki_d;
      kj_q        <= kj_d;
      wptr_q      <= wptr_d;
      inst_q      <= inst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      core_rst_q  <= core_rst_d;
    end
  end

  assign inst      = inst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign core_rst  = core_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_inst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_inst_sequencer: scoreboard bench for conv_inst_sequencer.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_conv_inst_sequencer;

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic        busy0, done0, ov0, crst0;
  logic        busy1, done1, ov1, crst1;
  logic [1:0]  oidx0;
  logic [3:0]  oidx1;
  logic [33:0] inst0, inst1;

  always #5 clk = ~clk;

  conv_inst_sequencer dut0 (
    .clk(clk), .reset(reset), .start(start0), .ofifo_valid(ofifo_valid),
    .busy(busy0), .done(done0), .out_valid(ov0), .out_idx(oidx0),
    .core_rst(crst0), .inst(inst0)
  );

  conv_inst_sequencer #(.IN_W(6), .COL(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ofifo_valid(ofifo_valid),
    .busy(busy1), .done(done1), .out_valid(ov1), .out_idx(oidx1),
    .core_rst(crst1), .inst(inst1)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          rd_log[$];
  int          wr_cnt = 0, acc_cnt = 0, load_cnt = 0, exec_cnt = 0, ov_cnt = 0, crst_cnt = 0;

  function automatic logic [31:0] ev(input int kind, input int data);
    logic [31:0] r;
    r = {kind[3:0], data[27:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input string name, input logic [31:0] got);
    logic [31:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got event %h expected none", name, got);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        n_fail++;
        $display("FAIL %s: got event %h expected %h", name, got, e);
      end
    end
  endtask

  // Expected event stream of one run; stop_kij >= 0 ends after that kij's activation load
  task automatic push_run(input int col, input int in_w, input int stop_kij);
    int nij, ow, wp;
    nij = in_w * in_w;
    ow  = in_w - 2;
    wp  = 0;
    for (int kij = 0; kij < 9; kij++) begin
      for (int t = 0; t < col; t++) exp_q.push_back(ev(1, (3 << 11) | ('h400 + kij * col + t)));
      for (int t = 0; t < nij; t++) exp_q.push_back(ev(1, (3 << 11) | t));
      if (kij == stop_kij) return;
      for (int t = 0; t < nij; t++) begin
        exp_q.push_back(ev(2, (1 << 11) | wp));
        wp++;
      end
    end
    for (int o = 0; o < ow * ow; o++) begin
      for (int j = 0; j < 9; j++)
        exp_q.push_back(ev(3, j * nij + ((o / ow) + (j / 3)) * in_w + (o % ow) + (j % 3)));
      exp_q.push_back(ev(4, o));
    end
    exp_q.push_back(ev(5, 0));
  endtask

  task automatic mon_one(input logic [33:0] in, input logic ov, input int idx,
                         input logic dn, input logic bz, input logic st, input logic cr);
    if (st && !bz && !reset) begin
      wr_cnt = 0; acc_cnt = 0; load_cnt = 0; exec_cnt = 0; ov_cnt = 0; crst_cnt = 0;
      rd_log.delete();
    end
    if (bz) check("ififo_zero", 64'(in[5:4]), 64'd0);
    if (!in[19])
      expect_evt("xmem_rd", ev(1, (int'(in[2]) << 12) | (int'(in[18]) << 11) | int'(in[17:7])));
    if (!in[32]) begin
      if (!in[31]) begin
        wr_cnt++;
        expect_evt("pmem_wr", ev(2, (int'(in[6]) << 11) | int'(in[30:20])));
      end else begin
        rd_log.push_back(int'(in[30:20]));
        expect_evt("pmem_rd", ev(3, (int'(in[6]) << 11) | int'(in[30:20])));
      end
    end
    if (in[33]) acc_cnt++;
    if (in[0])  load_cnt++;
    if (in[1])  exec_cnt++;
    if (cr)     crst_cnt++;
    if (ov) begin
      ov_cnt++;
      expect_evt("out_idx", ev(4, idx));
      check("acc_cycles", 64'(acc_cnt), 64'd9);
      acc_cnt = 0;
    end
    if (dn) expect_evt("done", ev(5, 0));
  endtask

  task automatic mon_loop();
    forever begin
      @(negedge clk);
      mon_one(inst0, ov0, int'(oidx0), done0, busy0, start0, crst0);
      mon_one(inst1, ov1, int'(oidx1), done1, busy1, start1, crst1);
    end
  endtask

  task automatic wait_done(input int d, input int budget);
    int  lowb;
    bit  seen;
    lowb = 0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if ((d == 0) ? done0 : done1) seen = 1'b1;
      else if (!((d == 0) ? busy0 : busy1)) lowb++;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("busy_until_done", 64'(lowb), 64'd0);
    @(negedge clk);
  endtask

  task automatic pulse_start0();
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    check("busy_after_start", 64'(busy0), 64'd1);
  endtask

  int acc0_addr[9] = '{0, 17, 34, 52, 69, 86, 104, 121, 138};

  task automatic check_default_run();
    check("pmem_writes", 64'(wr_cnt), 64'd144);
    check("out_valid_cnt", 64'(ov_cnt), 64'd4);
    check("load_cycles", 64'(load_cnt), 64'd72);
    check("exec_cycles", 64'(exec_cnt), 64'd144);
    check("core_rst_cycles", 64'(crst_cnt), 64'd26);
    for (int j = 0; j < 9; j++) check("acc_o0_addr", 64'(rd_log[j]), 64'(acc0_addr[j]));
    check("acc_o3_first", 64'(rd_log[27]), 64'd5);
    check("acc_o3_last", 64'(rd_log[35]), 64'd143);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit hit;
    fork
      mon_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_inst", 64'(inst0), 64'(IDLE_INST));
      check("idle_busy", 64'(busy0), 64'd0);
      check("idle_done", 64'(done0), 64'd0);
      check("idle_core_rst", 64'(crst0), 64'd0);
      check("idle_out_valid", 64'(ov0), 64'd0);
      check("idle_inst_w6", 64'(inst1), 64'(IDLE_INST));
    end

    // Full default run with a 3-cycle OFIFO stall inside kij 2 psum writes
    push_run(8, 4, -1);
    pulse_start0();
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      if (wr_cnt >= 37) hit = 1'b1;
    end
    check("reach_kij2_pwr", 64'(hit), 64'd1);
    ofifo_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_no_pmem", 64'(inst0[32]), 64'd1);
    end
    ofifo_valid = 1'b1;
    wait_done(0, 6000);
    check_default_run();

    // Abort during EXEC of kij 4
    push_run(8, 4, 4);
    pulse_start0();
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #1;
      if (exec_cnt >= 67) hit = 1'b1;
    end
    check("reach_kij4_exec", 64'(hit), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_inst", 64'(inst0), 64'(IDLE_INST));
    check("abort_busy", 64'(busy0), 64'd0);
    check("abort_core_rst", 64'(crst0), 64'd0);
    check("abort_queue", 64'(exp_q.size()), 64'd0);
    reset = 1'b0;
    exp_q.delete();

    // Fresh run after abort restarts at kij 0 with psum pointer at base
    push_run(8, 4, -1);
    pulse_start0();
    wait_done(0, 6000);
    check_default_run();

    // Wider config with start held high across most of the run
    push_run(16, 6, -1);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1;
    check("busy_w6", 64'(busy1), 64'd1);
    repeat (300) @(posedge clk);
    #1 start1 = 1'b0;
    wait_done(1, 6000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no_restart_w6", 64'(busy1), 64'd0);
    end
    check("out_valid_cnt_w6", 64'(ov_cnt), 64'd16);
    check("pmem_writes_w6", 64'(wr_cnt), 64'd324);
    check("load_cycles_w6", 64'(load_cnt), 64'd144);
    check("core_rst_cycles_w6", 64'(crst_cnt), 64'd50);
    check("acc_o15_last", 64'(rd_log[143]), 64'd323);
    check("queue_drained_w6", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
